// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: mix FSM encoding, the rest code
// and the saturation helper used when the mixed sum is delivered.
package voice_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mix_state_t;

  localparam int REST_NOTE = 0;

  // Clamp a signed value into the signed range of a width-bit sample.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Bus between the scheduler and the voice datapath: note loading, activity
// levels and the shared polled sample path.
//
// Handshake: voice_gen is a one-hot, one-cycle request to a single voice. That
// voice later answers with voice_sample_valid high for one cycle together with
// voice_sample; the scheduler takes an answer only while it waits on a poll,
// so a stray valid at any other time is ignored.
interface voice_scheduler_if #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int SAMPLE_W   = 16
);
  logic [NUM_VOICES-1:0] voice_load;
  logic [NOTE_W-1:0]     voice_note;
  logic [NUM_VOICES-1:0] voice_active;
  logic [NUM_VOICES-1:0] voice_gen;
  logic [SAMPLE_W-1:0]   voice_sample;
  logic                  voice_sample_valid;

  modport master (
    output voice_load, voice_note, voice_active, voice_gen,
    input  voice_sample, voice_sample_valid
  );

  modport slave (
    input  voice_load, voice_note, voice_active, voice_gen,
    output voice_sample, voice_sample_valid
  );
endinterface

// File: rtl/voice_scheduler_allocator.sv
// Per-voice note bookkeeping: picks a voice for each accepted note (idle first,
// otherwise steal the one closest to finishing) and counts durations on beat.
module voice_allocator
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  load_new_note,
  input  logic [NOTE_W-1:0]     note_to_load,
  input  logic [DUR_W-1:0]      duration_to_load,
  input  logic                  beat,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [NUM_VOICES-1:0] voice_active
);

  localparam int VIDX_W = $clog2(NUM_VOICES);

  logic [DUR_W-1:0]      remaining [NUM_VOICES];
  logic                  accept;
  logic                  found_idle;
  logic [VIDX_W-1:0]     sel;
  logic [DUR_W-1:0]      best;
  logic [NUM_VOICES-1:0] load_vec;

  always_comb begin
    accept = load_new_note && play &&
             (note_to_load != NOTE_W'(REST_NOTE)) && (duration_to_load != '0);
    found_idle = 1'b0;
    sel        = '0;
    best       = remaining[0];
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_active[i]) begin
        found_idle = 1'b1;
        sel        = VIDX_W'(i);
      end
    end
    // Idle voices always hold 0, so the steal scan only matters when all are busy;
    // strict less-than keeps ties on the lowest index.
    if (!found_idle) begin
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (remaining[i] < best) begin
          best = remaining[i];
          sel  = VIDX_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      load_vec[i] = accept && (sel == VIDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voice_load   <= '0;
      voice_note   <= '0;
      voice_active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) remaining[i] <= '0;
    end else begin
      voice_load <= load_vec;
      voice_note <= accept ? note_to_load : '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_vec[i]) begin
          remaining[i]    <= duration_to_load;
          voice_active[i] <= 1'b1;
        end else if (beat && play && voice_active[i]) begin
          remaining[i] <= remaining[i] - DUR_W'(1);
          if (remaining[i] == DUR_W'(1)) voice_active[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler top: note allocation plus the mix FSM that polls each active
// voice over the shared sample bus and delivers one saturated mixed sample.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int NOTE_W       = 6,
  parameter int DUR_W        = 6,
  parameter int SAMPLE_W     = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic                load_new_note,
  input  logic [NOTE_W-1:0]   note_to_load,
  input  logic [DUR_W-1:0]    duration_to_load,
  input  logic                beat,
  input  logic                generate_next_sample,
  voice_scheduler_if.master   vbus,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready,
  output logic                busy,
  output mix_state_t          dbg_state
);

  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int IDX_W  = $clog2(NUM_VOICES + 1);
  localparam int TMR_W  = $clog2(WAIT_TIMEOUT + 1);

  voice_allocator #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W),
    .DUR_W      (DUR_W)
  ) u_alloc (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .load_new_note    (load_new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .beat             (beat),
    .voice_load       (vbus.voice_load),
    .voice_note       (vbus.voice_note),
    .voice_active     (vbus.voice_active)
  );

  mix_state_t              state, state_nxt;
  logic [NUM_VOICES-1:0]   mask;
  logic [NUM_VOICES-1:0]   cur_onehot;
  logic [NUM_VOICES-1:0]   gen_vec;
  logic [IDX_W-1:0]        idx;
  logic [VIDX_W-1:0]       cur;
  logic [VIDX_W-1:0]       pick;
  logic                    pick_found;
  logic signed [ACC_W-1:0] acc;
  logic [TMR_W-1:0]        timer;
  logic                    got_sample;
  logic                    timed_out;
  logic                    rest_left;

  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(idx))) begin
        pick       = VIDX_W'(i);
        pick_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) cur_onehot[i] = (cur == VIDX_W'(i));
    got_sample = (state == ST_WAIT) && vbus.voice_sample_valid;
    timed_out  = (state == ST_WAIT) && !vbus.voice_sample_valid &&
                 (timer == TMR_W'(WAIT_TIMEOUT - 1));
    rest_left  = |(mask & ~cur_onehot);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (generate_next_sample)
                 state_nxt = (vbus.voice_active == '0 || !play) ? ST_DONE : ST_REQ;
      ST_REQ:  state_nxt = pick_found ? ST_WAIT : ST_DONE;
      ST_WAIT: if (got_sample || timed_out)
                 state_nxt = rest_left ? ST_REQ : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    dbg_state = state;
    for (int i = 0; i < NUM_VOICES; i++) begin
      gen_vec[i] = (state == ST_REQ) && pick_found && (pick == VIDX_W'(i));
    end
  end

  assign vbus.voice_gen = gen_vec;

  // The mask is a snapshot: voices stolen or ended mid-mix are still polled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask             <= '0;
      idx              <= '0;
      cur              <= '0;
      acc              <= '0;
      timer            <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= 1'b0;
      case (state)
        ST_IDLE: if (generate_next_sample) begin
          mask <= vbus.voice_active;
          acc  <= '0;
          idx  <= '0;
        end
        ST_REQ: begin
          cur   <= pick;
          idx   <= IDX_W'(pick) + IDX_W'(1);
          timer <= '0;
        end
        ST_WAIT: begin
          if (got_sample) begin
            acc  <= acc + $signed({{(ACC_W - SAMPLE_W){vbus.voice_sample[SAMPLE_W-1]}},
                                   vbus.voice_sample});
            mask <= mask & ~cur_onehot;
          end else if (timed_out) begin
            mask <= mask & ~cur_onehot;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_DONE: begin
          sample_out       <= SAMPLE_W'(saturate({{(32 - ACC_W){acc[ACC_W-1]}}, acc}, SAMPLE_W));
          new_sample_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, stealing, beat counting,
// mixing with saturation, timeout and mid-mix reset.
module tb_voice_scheduler;
  import voice_scheduler_pkg::*;

  localparam int NV     = 4;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int SW     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              play = 1'b0;
  logic              load_new_note = 1'b0;
  logic [NOTE_W-1:0] note_to_load = '0;
  logic [DUR_W-1:0]  duration_to_load = '0;
  logic              beat = 1'b0;
  logic              generate_next_sample = 1'b0;
  logic [SW-1:0]     sample_out;
  logic              new_sample_ready;
  logic              busy;
  mix_state_t        dbg_state;

  voice_scheduler_if #(.NUM_VOICES(NV), .NOTE_W(NOTE_W), .SAMPLE_W(SW)) vbus();

  voice_scheduler #(
    .NUM_VOICES(NV), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SAMPLE_W(SW), .WAIT_TIMEOUT(64)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .load_new_note        (load_new_note),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .vbus                 (vbus),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .busy                 (busy),
    .dbg_state            (dbg_state)
  );

  // Clock and bookkeeping
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NV-1:0] gen_log[$];
  logic [NV-1:0] exp_q[$];

  // Voice datapath model: answers a poll reply_lat cycles after voice_gen.
  logic          reply_en = 1'b0;
  int            reply_lat = 1;
  logic [SW-1:0] reply_val [NV];

  initial begin
    vbus.voice_sample       = '0;
    vbus.voice_sample_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (vbus.voice_gen != '0) begin
        int v;
        v = 0;
        for (int i = 0; i < NV; i++) if (vbus.voice_gen[i]) v = i;
        gen_log.push_back(vbus.voice_gen);
        if (reply_en) begin
          repeat (reply_lat) @(posedge clk);
          #1;
          vbus.voice_sample_valid = 1'b1;
          vbus.voice_sample       = reply_val[v];
          @(posedge clk);
          #1;
          vbus.voice_sample_valid = 1'b0;
          vbus.voice_sample       = '0;
        end
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic load_note(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
    load_new_note    = 1'b1;
    note_to_load     = n;
    duration_to_load = d;
    tick(1);
    load_new_note    = 1'b0;
  endtask

  task automatic do_beats(input int n);
    repeat (n) begin
      beat = 1'b1;
      tick(1);
      beat = 1'b0;
    end
  endtask

  task automatic request_mix(output int lat);
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    lat = 1;
    while (!new_sample_ready && lat < 300) begin
      tick(1);
      lat++;
    end
  endtask

  // Scoreboard for the order of polled voices
  task automatic check_polls(input string tag);
    check({tag, "_count"}, 32'(gen_log.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && gen_log.size() > 0)
      check(tag, 32'(gen_log.pop_front()), 32'(exp_q.pop_front()));
    gen_log.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    int extra;
    for (int i = 0; i < NV; i++) reply_val[i] = '0;

    // Reset state
    tick(2);
    check("rst_active", 32'(vbus.voice_active), 32'h0);
    check("rst_load", 32'(vbus.voice_load), 32'h0);
    check("rst_gen", 32'(vbus.voice_gen), 32'h0);
    check("rst_sample", 32'(sample_out), 32'h0);
    check("rst_ready", 32'(new_sample_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    play  = 1'b1;
    tick(1);

    // Single note, 3 beats
    load_note(6'd10, 6'd3);
    check("t1_load", 32'(vbus.voice_load), 32'h1);
    check("t1_note", 32'(vbus.voice_note), 32'd10);
    check("t1_active", 32'(vbus.voice_active), 32'h1);
    tick(1);
    check("t1_load_pulse", 32'(vbus.voice_load), 32'h0);
    do_beats(2);
    check("t1_active_b2", 32'(vbus.voice_active), 32'h1);
    do_beats(1);
    check("t1_active_b3", 32'(vbus.voice_active), 32'h0);

    // Fill all voices, then steal the one with least remaining
    load_note(6'd1, 6'd5);
    load_note(6'd2, 6'd2);
    load_note(6'd3, 6'd7);
    load_note(6'd4, 6'd4);
    check("t2_full", 32'(vbus.voice_active), 32'hF);
    load_note(6'd5, 6'd3);
    check("t2_steal", 32'(vbus.voice_load), 32'h2);
    check("t2_steal_note", 32'(vbus.voice_note), 32'd5);
    do_beats(4);
    check("t2_active_b4", 32'(vbus.voice_active), 32'h5);

    // Mix voices 0 and 2: positive saturation
    reply_en     = 1'b1;
    reply_lat    = 1;
    reply_val[0] = 16'd20000;
    reply_val[2] = 16'd20000;
    gen_log.delete();
    request_mix(lat);
    check("t3_latency", 32'(lat), 32'd6);
    check("t3_sat_pos", 32'(sample_out), 32'h7FFF);
    check("t3_busy", 32'(busy), 32'h0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    check_polls("t3_poll");

    reply_val[0] = 16'(-20000);
    reply_val[2] = 16'(-20000);
    request_mix(lat);
    check("t3_sat_neg", 32'(sample_out), 32'h8000);

    reply_val[0] = 16'd1000;
    reply_val[2] = 16'(-3000);
    request_mix(lat);
    check("t3_sum", 32'(sample_out), 32'hF830);
    gen_log.delete();

    // Empty mix; second request while busy is dropped
    do_beats(3);
    check("t4_idle", 32'(vbus.voice_active), 32'h0);
    generate_next_sample = 1'b1;
    tick(1);
    check("t4_busy", 32'(busy), 32'h1);
    tick(1);
    generate_next_sample = 1'b0;
    check("t4_ready", 32'(new_sample_ready), 32'h1);
    check("t4_sample", 32'(sample_out), 32'h0);
    extra = 0;
    repeat (4) begin
      tick(1);
      if (new_sample_ready) extra++;
    end
    check("t4_no_requeue", 32'(extra), 32'h0);
    check("t4_no_polls", 32'(gen_log.size()), 32'h0);

    // One voice answering, then the same voice silent (timeout)
    load_note(6'd5, 6'd5);
    check("t5_load", 32'(vbus.voice_load), 32'h1);
    reply_val[0] = 16'd1234;
    request_mix(lat);
    check("t5_latency", 32'(lat), 32'd4);
    check("t5_sample", 32'(sample_out), 32'h04D2);
    reply_en = 1'b0;
    request_mix(lat);
    check("t5_timeout_lat", 32'(lat), 32'd67);
    check("t5_timeout_smp", 32'(sample_out), 32'h0);
    gen_log.delete();

    // Beat coincident with a steal-reload of the same voice
    load_note(6'd6, 6'd9);
    load_note(6'd7, 6'd9);
    load_note(6'd8, 6'd9);
    check("t6_load_v3", 32'(vbus.voice_load), 32'h8);
    load_new_note    = 1'b1;
    note_to_load     = 6'd9;
    duration_to_load = 6'd7;
    beat             = 1'b1;
    tick(1);
    load_new_note = 1'b0;
    beat          = 1'b0;
    check("t6_reload", 32'(vbus.voice_load), 32'h1);
    do_beats(6);
    check("t6_active_b6", 32'(vbus.voice_active), 32'hF);

    // play=0 freezes counts and blocks loads
    play = 1'b0;
    do_beats(2);
    check("t7_frozen", 32'(vbus.voice_active), 32'hF);
    load_note(6'd11, 6'd4);
    check("t7_no_load", 32'(vbus.voice_load), 32'h0);
    play = 1'b1;
    do_beats(1);
    check("t7_v0_done", 32'(vbus.voice_active), 32'hE);
    do_beats(1);
    check("t7_all_done", 32'(vbus.voice_active), 32'h0);
    load_note(6'd0, 6'd5);
    check("t7_rest_drop", 32'(vbus.voice_load), 32'h0);
    load_note(6'd12, 6'd0);
    check("t7_dur0_drop", 32'(vbus.voice_load), 32'h0);
    check("t7_still_idle", 32'(vbus.voice_active), 32'h0);

    // Reset while waiting on a slow voice
    load_note(6'd13, 6'd9);
    reply_en     = 1'b1;
    reply_lat    = 20;
    reply_val[0] = 16'd777;
    generate_next_sample = 1'b1;
    tick(1);
    generate_next_sample = 1'b0;
    tick(4);
    check("t8_busy", 32'(busy), 32'h1);
    check("t8_wait", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b0;
    #1;
    check("t8_rst_active", 32'(vbus.voice_active), 32'h0);
    check("t8_rst_busy", 32'(busy), 32'h0);
    check("t8_rst_gen", 32'(vbus.voice_gen), 32'h0);
    check("t8_rst_sample", 32'(sample_out), 32'h0);
    extra = 0;
    repeat (3) begin
      tick(1);
      if (new_sample_ready) extra++;
    end
    reset = 1'b1;
    repeat (25) begin
      tick(1);
      if (new_sample_ready) extra++;
    end
    check("t8_no_ready", 32'(extra), 32'h0);
    check("t8_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t8_sample", 32'(sample_out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
